// File: rtl/sfixed_p_std_sdiv_pipe.sv
// Multi-cycle signed fixed-point divider (bit-serial restoring, MSB first) with go/done handshake.
// Define SFIXED_DIV_SAT_EN to saturate on overflow and divide-by-zero instead of wrapping / returning 0.
module sfixed_p_std_sdiv_pipe #(
    parameter int width       = 32,
    parameter int int_width   = 8,
    parameter int fract_width = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             done
);

    localparam int N  = width + fract_width;
    localparam int CW = $clog2(N);
    localparam logic [width-1:0] MAX_VAL = {1'b0, {(width - 1){1'b1}}};
    localparam logic [width-1:0] MIN_VAL = {1'b1, {(width - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             sign;
    logic [width-1:0] divisor;
    logic [N-1:0]     dq;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [width:0]   rem;

    logic [width-1:0] left_mag, right_mag;
    logic [width:0]   trial;
    logic             fits;
    logic [width:0]   rem_step;
    logic [N-1:0]     q_final;
    logic             last_step;
    logic             ovf;
    logic [width-1:0] mag_low, wrapped, result, dz_value;

    assign left_mag  = left[width-1]  ? -left  : left;
    assign right_mag = right[width-1] ? -right : right;

    // A set top remainder bit means the shifted value already exceeds the divisor;
    // the modular subtraction below still yields the correct (smaller) remainder.
    assign trial     = {rem[width-1:0], dq[N-1]};
    assign fits      = rem[width] | (trial >= {1'b0, divisor});
    assign rem_step  = fits ? trial - {1'b0, divisor} : trial;
    assign q_final   = {dq[N-2:0], fits};
    assign last_step = (cnt == CW'(N - 1));

    assign ovf = sign ? ((|q_final[N-1:width]) | (q_final[width-1] & (|q_final[width-2:0])))
                      : (|q_final[N-1:width-1]);

    assign mag_low = q_final[width-1:0];
    assign wrapped = sign ? -mag_low : mag_low;

`ifdef SFIXED_DIV_SAT_EN
    assign result   = ovf ? (sign ? MIN_VAL : MAX_VAL) : wrapped;
    assign dz_value = left[width-1] ? MIN_VAL : MAX_VAL;
`else
    assign result   = wrapped;
    assign dz_value = '0;
`endif

    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = (right == '0) ? DONE : BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            sign         <= 1'b0;
            divisor      <= '0;
            dq           <= '0;
            rem          <= '0;
            out_quotient <= '0;
            div_by_zero  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        cnt     <= '0;
                        sign    <= left[width-1] ^ right[width-1];
                        divisor <= right_mag;
                        dq      <= {left_mag, {fract_width{1'b0}}};
                        rem     <= '0;
                        if (right == '0) begin
                            out_quotient <= dz_value;
                            div_by_zero  <= 1'b1;
                            overflow     <= 1'b0;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    dq  <= q_final;
                    rem <= rem_step;
                    if (last_step) begin
                        out_quotient <= result;
                        div_by_zero  <= 1'b0;
                        overflow     <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sfixed_p_std_sdiv_pipe.sv
// Scoreboard bench for sfixed_p_std_sdiv_pipe: driver pushes model results, a negedge monitor pops on done.
// Honours SFIXED_DIV_SAT_EN the same way the design does.
module tb_sfixed_p_std_sdiv_pipe;

    localparam int W  = 32;
    localparam int FW = 24;
    localparam int N  = W + FW;
    localparam longint MAXP = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINP = -(longint'(1) <<< (W - 1));
    localparam logic [31:0] MAXV = 32'h7FFF_FFFF;
    localparam logic [31:0] MINV = 32'h8000_0000;

`ifdef SFIXED_DIV_SAT_EN
    localparam logic [31:0] Q_DZ   = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_OVF1 = 32'h7FFF_FFFF;
    localparam logic [31:0] Q_OVF2 = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] Q_DZ   = 32'h0000_0000;
    localparam logic [31:0] Q_OVF1 = 32'hC800_0000;
    localparam logic [31:0] Q_OVF2 = 32'h8000_0000;
`endif

    typedef struct {
        logic [31:0] q;
        logic        dz;
        logic        ovf;
        int          issue;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [31:0] left, right;
    logic [31:0] out_quotient;
    logic        div_by_zero, overflow, done;

    exp_t sb[$];
    int   cyc = 0;
    int   done_count = 0;
    int   last_done = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    sfixed_p_std_sdiv_pipe #(.width(W), .int_width(8), .fract_width(FW)) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .left         (left),
        .right        (right),
        .out_quotient (out_quotient),
        .div_by_zero  (div_by_zero),
        .overflow     (overflow),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: exact fixed-point quotient with integer division (truncates toward zero).
    function automatic exp_t model(input logic [31:0] l, input logic [31:0] r);
        exp_t   e;
        longint a, b, q;
        e.issue = 0;
        e.lat   = N;
        e.dz    = 1'b0;
        e.ovf   = 1'b0;
        if (r == 32'd0) begin
            e.dz  = 1'b1;
            e.lat = 0;
`ifdef SFIXED_DIV_SAT_EN
            e.q = l[31] ? MINV : MAXV;
`else
            e.q = 32'd0;
`endif
            return e;
        end
        a = longint'($signed(l)) * (longint'(1) <<< FW);
        b = longint'($signed(r));
        q = a / b;
        e.ovf = (q > MAXP) || (q < MINP);
        e.q   = q[31:0];
`ifdef SFIXED_DIV_SAT_EN
        if (e.ovf) e.q = (q < 0) ? MINV : MAXV;
`endif
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && done === 1'b1) begin
            done_count++;
            last_done = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("quotient", out_quotient, e.q);
                check("div_by_zero", div_by_zero, e.dz);
                check("overflow", overflow, e.ovf);
                check("latency", cyc - e.issue, e.lat);
            end
        end
    end

    task automatic wait_done(input int start);
        int t = 0;
        while (done_count == start && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("done_seen", done_count != start, 1);
    endtask

    // Called just after a negedge with the DUT idle; returns just after a negedge with the DUT idle.
    task automatic do_op(input logic [31:0] l, input logic [31:0] r,
                         input bit has_lit, input logic [31:0] lit_q, input bit perturb);
        exp_t e;
        int   start;
        e = model(l, r);
        if (has_lit) e.q = lit_q;
        start = done_count;
        left  = l;
        right = r;
        go    = 1'b1;
        @(posedge clk);
        #1;
        e.issue = cyc;
        sb.push_back(e);
        @(negedge clk);
        #1;
        go = 1'b0;
        if (perturb && r != 32'd0) begin
            repeat (6) @(negedge clk);
            left  = $urandom;
            right = $urandom;
            go    = 1'b1;
            @(negedge clk);
            go = 1'b0;
        end
        wait_done(start);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e1, e2;
        int   start, d1;
        logic [31:0] l, r;

        reset = 1'b0;
        go    = 1'b0;
        left  = '0;
        right = '0;
        repeat (3) @(negedge clk);
        check("reset_quotient", out_quotient, 32'd0);
        check("reset_dz", div_by_zero, 1'b0);
        check("reset_ovf", overflow, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        do_op(32'h0600_0000, 32'h0200_0000, 1, 32'h0300_0000, 0);
        do_op(32'hFF00_0000, 32'h0300_0000, 1, 32'hFFAA_AAAB, 0);
        do_op(32'h0100_0000, 32'h0000_0000, 1, Q_DZ, 0);
        do_op(32'h6400_0000, 32'h0080_0000, 1, Q_OVF1, 0);
        do_op(32'h8000_0000, 32'hFF00_0000, 1, Q_OVF2, 0);

        // Abort an op around iteration 20 with reset; no done may follow.
        left  = 32'h0600_0000;
        right = 32'h0200_0000;
        go    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_quotient", out_quotient, 32'd0);
        check("abort_ovf", overflow, 1'b0);
        check("abort_done", done, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_done_held", done, 1'b0);
        reset = 1'b1;
        start = done_count;
        repeat (70) @(negedge clk);
        #1;
        check("no_done_after_abort", done_count, start);
        check("quotient_after_abort", out_quotient, 32'd0);
        @(negedge clk);

        do_op(32'h0600_0000, 32'h0200_0000, 1, 32'h0300_0000, 0);

        // go held high across completion starts a second op two cycles later.
        e1 = model(32'h0600_0000, 32'h0200_0000);
        left  = 32'h0600_0000;
        right = 32'h0200_0000;
        go    = 1'b1;
        start = done_count;
        @(posedge clk);
        #1;
        e1.issue = cyc;
        e2 = e1;
        e2.issue = cyc + N + 2;
        sb.push_back(e1);
        sb.push_back(e2);
        wait_done(start);
        d1 = last_done;
        wait_done(start + 1);
        go = 1'b0;
        check("b2b_spacing", last_done - d1, N + 2);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            l = $urandom;
            r = $urandom;
            case ($urandom_range(0, 5))
                0: r = 32'd0;
                1: r = $urandom_range(1, 255);
                2: r = 32'h8000_0000;
                3: l = 32'h8000_0000;
                4: r = {8'h00, 24'($urandom)};
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1 && r != 32'h8000_0000) r = -r;
            do_op(l, r, 0, 32'd0, 1);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
